// File: rtl/cu_pkg.sv
// Shared constants for the single-bus CPU control sequencer: opcodes,
// ALU operation codes, bus-source / register-enable bit positions, the
// step (state) encoding, the opcode class and the registered output bundle.
package cu_pkg;

    // Opcodes carried in IR[31:27]
    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    // ALU operation codes driven on ALU_Sel
    localparam logic [5:0] ALU_NONE = 6'd0;
    localparam logic [5:0] ALU_AND  = 6'd5;
    localparam logic [5:0] ALU_OR   = 6'd6;
    localparam logic [5:0] ALU_ADD  = 6'd13;
    localparam logic [5:0] ALU_SUB  = 6'd14;

    // Bus-source bit positions in enc_input
    localparam int unsigned BUS_ZLOW = 19;
    localparam int unsigned BUS_PC   = 20;
    localparam int unsigned BUS_MDR  = 22;
    localparam int unsigned BUS_C    = 25;

    // Register-load bit positions in reg_enable
    localparam int unsigned EN_Z   = 19;
    localparam int unsigned EN_PC  = 20;
    localparam int unsigned EN_IR  = 21;
    localparam int unsigned EN_MDR = 22;
    localparam int unsigned EN_MAR = 23;
    localparam int unsigned EN_Y   = 24;

    // One control step per state; IDLE and HALT drive nothing
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    // Instruction families that share an execute sequence.
    // addi shares the LDI sequence, differing only in how Rb is driven.
    typedef enum logic [2:0] {
        CL_NOP  = 3'd0,
        CL_LDI  = 3'd1,
        CL_LD   = 3'd2,
        CL_ST   = 3'd3,
        CL_ALU  = 3'd4,
        CL_HALT = 3'd5
    } op_class_t;

    // Everything the sequencer drives, kept together so it can be registered as one
    typedef struct packed {
        logic [31:0] enc_input;
        logic [31:0] reg_enable;
        logic [5:0]  alu_sel;
        logic        inc_pc;
        logic        read;
        logic        write;
        logic        gra;
        logic        grb;
        logic        grc;
        logic        rin;
        logic        rout;
        logic        ba_out;
        logic        run;
    } cu_out_t;

    // One-hot 32-bit vector with bit idx set
    function automatic logic [31:0] sel_bit(input int unsigned idx);
        sel_bit = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decode: maps IR[31:27] to an instruction class,
// flags addi (Rb driven as a register rather than as a base address) and
// gives the ALU operation used in step T4. Unlisted opcodes decode as nop.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic       base_rout,
    output logic [5:0] alu_sel
);

    // Opcode to class / ALU mapping; address-forming instructions all add
    always_comb begin
        op_class  = CL_NOP;
        base_rout = 1'b0;
        alu_sel   = ALU_NONE;
        case (opcode)
            OP_LD: begin
                op_class = CL_LD;
                alu_sel  = ALU_ADD;
            end
            OP_LDI: begin
                op_class = CL_LDI;
                alu_sel  = ALU_ADD;
            end
            OP_ST: begin
                op_class = CL_ST;
                alu_sel  = ALU_ADD;
            end
            OP_ADDI: begin
                op_class  = CL_LDI;
                base_rout = 1'b1;
                alu_sel   = ALU_ADD;
            end
            OP_ADD: begin
                op_class = CL_ALU;
                alu_sel  = ALU_ADD;
            end
            OP_SUB: begin
                op_class = CL_ALU;
                alu_sel  = ALU_SUB;
            end
            OP_AND: begin
                op_class = CL_ALU;
                alu_sel  = ALU_AND;
            end
            OP_OR: begin
                op_class = CL_ALU;
                alu_sel  = ALU_OR;
            end
            OP_HALT: begin
                op_class = CL_HALT;
            end
            default: begin
                op_class = CL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore control sequencer for the single-bus CPU datapath.
// Fetch T0-T2, decode IR[31:27], execute ld/ldi/st/add/sub/and/or/addi/nop/halt.
// Optional build macro CU_MEM_WAIT_EN: when defined, the memory steps
// (T1 of every fetch, T6 of ld, T7 of st) hold until mem_rdy is high;
// when undefined, mem_rdy is ignored and every step takes one clock.
//
// All outputs are flops loaded with the decode of the state being entered,
// so they are a pure function of the state register and the latched opcode,
// and the asynchronous clr clears them immediately.
module control_unit
    import cu_pkg::*;
(
    input  logic        clock,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic [31:0] enc_input,
    output logic [31:0] reg_enable,
    output logic        incPC,
    output logic        read,
    output logic        write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [5:0]  ALU_Sel,
    output logic        run
);

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  op_q;
    logic [4:0]  op_d;
    cu_out_t     out_q;
    cu_out_t     out_d;

    op_class_t   cls_d;
    logic        base_rout_d;
    logic [5:0]  alu_sel_d;
    logic        mem_go;

    // Only the opcode field of IR steers the sequencer
    logic [26:0] ir_unused;
    assign ir_unused = ir[26:0];

`ifdef CU_MEM_WAIT_EN
    // Memory steps complete on the edge where memory reports ready
    assign mem_go = mem_rdy;
`else
    // Memory always completes in a single step
    logic mem_rdy_unused;
    assign mem_go         = 1'b1;
    assign mem_rdy_unused = mem_rdy;
`endif

    // The opcode is captured on the edge leaving T2 and held for the rest of
    // the instruction, so later IR changes cannot disturb the execute steps.
    assign op_d = (state_q == ST_T2) ? ir[31:27] : op_q;

    cu_decode u_decode (
        .opcode    (op_d),
        .op_class  (cls_d),
        .base_rout (base_rout_d),
        .alu_sel   (alu_sel_d)
    );

    // Step sequencing: fetch, branch on class at T2, then the execute chain
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1: begin
                if (mem_go) begin
                    state_d = ST_T2;
                end
            end
            ST_T2: begin
                if (cls_d == CL_NOP) begin
                    state_d = ST_T0;
                end else if (cls_d == CL_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_T3;
                end
            end
            ST_T3: state_d = ST_T4;
            ST_T4: state_d = ST_T5;
            ST_T5: begin
                if ((cls_d == CL_LD) || (cls_d == CL_ST)) begin
                    state_d = ST_T6;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T6: begin
                // st only loads MDR here; ld waits for its memory read
                if ((cls_d == CL_ST) || mem_go) begin
                    state_d = ST_T7;
                end
            end
            ST_T7: begin
                // st waits for its memory write; ld writes back unconditionally
                if ((cls_d != CL_ST) || mem_go) begin
                    state_d = ST_T0;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control word for the step being entered; everything else stays 0
    always_comb begin
        out_d     = '0;
        out_d.run = (state_d != ST_IDLE) && (state_d != ST_HALT);
        case (state_d)
            ST_T0: begin
                // PC to MAR and bump PC
                out_d.enc_input  = sel_bit(BUS_PC);
                out_d.reg_enable = sel_bit(EN_MAR);
                out_d.inc_pc     = 1'b1;
            end
            ST_T1: begin
                // Instruction word into MDR
                out_d.read       = 1'b1;
                out_d.reg_enable = sel_bit(EN_MDR);
            end
            ST_T2: begin
                // MDR into IR
                out_d.enc_input  = sel_bit(BUS_MDR);
                out_d.reg_enable = sel_bit(EN_IR);
            end
            ST_T3: begin
                // First ALU operand into Y: base address (R0 reads 0) or a register
                out_d.grb        = 1'b1;
                out_d.reg_enable = sel_bit(EN_Y);
                if ((cls_d == CL_ALU) || base_rout_d) begin
                    out_d.rout = 1'b1;
                end else begin
                    out_d.ba_out = 1'b1;
                end
            end
            ST_T4: begin
                // Second operand on the bus, result into Z
                out_d.reg_enable = sel_bit(EN_Z);
                out_d.alu_sel    = alu_sel_d;
                if (cls_d == CL_ALU) begin
                    out_d.grc  = 1'b1;
                    out_d.rout = 1'b1;
                end else begin
                    out_d.enc_input = sel_bit(BUS_C);
                end
            end
            ST_T5: begin
                // Z either becomes the effective address or is written back
                out_d.enc_input = sel_bit(BUS_ZLOW);
                if ((cls_d == CL_LD) || (cls_d == CL_ST)) begin
                    out_d.reg_enable = sel_bit(EN_MAR);
                end else begin
                    out_d.gra = 1'b1;
                    out_d.rin = 1'b1;
                end
            end
            ST_T6: begin
                // ld reads memory into MDR; st loads Ra into MDR
                out_d.reg_enable = sel_bit(EN_MDR);
                if (cls_d == CL_ST) begin
                    out_d.gra  = 1'b1;
                    out_d.rout = 1'b1;
                end else begin
                    out_d.read = 1'b1;
                end
            end
            ST_T7: begin
                // st writes MDR to memory; ld moves MDR into Ra
                if (cls_d == CL_ST) begin
                    out_d.write = 1'b1;
                end else begin
                    out_d.enc_input = sel_bit(BUS_MDR);
                    out_d.gra       = 1'b1;
                    out_d.rin       = 1'b1;
                end
            end
            default: begin
                out_d = '0;
            end
        endcase
    end

    // State, latched opcode and registered control word; clr clears all at once
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    assign enc_input  = out_q.enc_input;
    assign reg_enable = out_q.reg_enable;
    assign incPC      = out_q.inc_pc;
    assign read       = out_q.read;
    assign write      = out_q.write;
    assign Gra        = out_q.gra;
    assign Grb        = out_q.grb;
    assign Grc        = out_q.grc;
    assign Rin        = out_q.rin;
    assign Rout       = out_q.rout;
    assign BAout      = out_q.ba_out;
    assign ALU_Sel    = out_q.alu_sel;
    assign run        = out_q.run;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. For each instruction a reference
// model lists, step by step, the control word the specification asks for
// (including memory wait repetitions), plus the mem_rdy and ir to drive
// in that step. Outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        mem_rdy = 1'b0;
    logic [31:0] enc_input;
    logic [31:0] reg_enable;
    logic        incPC;
    logic        read;
    logic        write;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic        BAout;
    logic [5:0]  ALU_Sel;
    logic        run;

    control_unit dut (
        .clock      (clock),
        .clr        (clr),
        .ir         (ir),
        .mem_rdy    (mem_rdy),
        .enc_input  (enc_input),
        .reg_enable (reg_enable),
        .incPC      (incPC),
        .read       (read),
        .write      (write),
        .Gra        (Gra),
        .Grb        (Grb),
        .Grc        (Grc),
        .Rin        (Rin),
        .Rout       (Rout),
        .BAout      (BAout),
        .ALU_Sel    (ALU_Sel),
        .run        (run)
    );

    always #5 clock = ~clock;

`ifdef CU_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    // Flag positions in the low 10 bits of a packed control word
    localparam logic [9:0] F_INC  = 10'h200;
    localparam logic [9:0] F_RD   = 10'h100;
    localparam logic [9:0] F_WR   = 10'h080;
    localparam logic [9:0] F_GRA  = 10'h040;
    localparam logic [9:0] F_GRB  = 10'h020;
    localparam logic [9:0] F_GRC  = 10'h010;
    localparam logic [9:0] F_RIN  = 10'h008;
    localparam logic [9:0] F_ROUT = 10'h004;
    localparam logic [9:0] F_BAO  = 10'h002;
    localparam logic [9:0] F_RUN  = 10'h001;

    logic [79:0] obs;
    assign obs = {enc_input, reg_enable, ALU_Sel, incPC, read, write,
                  Gra, Grb, Grc, Rin, Rout, BAout, run};

    int n_checks = 0;
    int n_errors = 0;

    logic [79:0] exp_q[$];
    logic        rdy_q[$];
    logic [31:0] irv_q[$];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Control word of one active step: bus source, load enable (-1 = none), ALU code, flags
    function automatic logic [79:0] mk(input int enc, input int en, input logic [5:0] alu,
                                       input logic [9:0] fl);
        logic [31:0] e;
        logic [31:0] r;
        e = (enc < 0) ? 32'd0 : (32'd1 << enc);
        r = (en < 0) ? 32'd0 : (32'd1 << en);
        return {e, r, alu, fl | F_RUN};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // mem_rdy for repetition k of a memory step that must wait w cycles
    function automatic logic mem_level(input int k, input int w);
        if (WAIT_EN) return (k == w);
        return rnd_bit();
    endfunction

    task automatic push(input logic [79:0] v, input logic r, input logic [31:0] x);
        exp_q.push_back(v);
        rdy_q.push_back(r);
        irv_q.push_back(x);
    endtask

    // Reference sequence of one instruction; w1 = fetch-read waits, wm = ld/st memory waits
    task automatic build(input logic [31:0] instr, input int w1, input int wm);
        int op;
        op = int'(instr[31:27]);
        exp_q.delete();
        rdy_q.delete();
        irv_q.delete();
        push(mk(20, 23, 6'd0, F_INC), rnd_bit(), instr);
        for (int k = 0; k <= w1; k++) push(mk(-1, 22, 6'd0, F_RD), mem_level(k, w1), instr);
        push(mk(22, 21, 6'd0, 10'd0), rnd_bit(), instr);
        case (op)
            0, 1, 2, 12: begin
                push(mk(-1, 24, 6'd0, F_GRB | ((op == 12) ? F_ROUT : F_BAO)), rnd_bit(), $urandom);
                push(mk(25, 19, 6'd13, 10'd0), rnd_bit(), $urandom);
                if (op == 0) begin
                    push(mk(19, 23, 6'd0, 10'd0), rnd_bit(), $urandom);
                    for (int k = 0; k <= wm; k++) push(mk(-1, 22, 6'd0, F_RD), mem_level(k, wm), $urandom);
                    push(mk(22, -1, 6'd0, F_GRA | F_RIN), rnd_bit(), $urandom);
                end else if (op == 2) begin
                    push(mk(19, 23, 6'd0, 10'd0), rnd_bit(), $urandom);
                    push(mk(-1, 22, 6'd0, F_GRA | F_ROUT), rnd_bit(), $urandom);
                    for (int k = 0; k <= wm; k++) push(mk(-1, -1, 6'd0, F_WR), mem_level(k, wm), $urandom);
                end else begin
                    push(mk(19, -1, 6'd0, F_GRA | F_RIN), rnd_bit(), $urandom);
                end
            end
            3, 4, 5, 6: begin
                logic [5:0] alu;
                alu = (op == 3) ? 6'd13 : (op == 4) ? 6'd14 : (op == 5) ? 6'd5 : 6'd6;
                push(mk(-1, 24, 6'd0, F_GRB | F_ROUT), rnd_bit(), $urandom);
                push(mk(-1, 19, alu, F_GRC | F_ROUT), rnd_bit(), $urandom);
                push(mk(19, -1, 6'd0, F_GRA | F_RIN), rnd_bit(), $urandom);
            end
            default: begin
            end
        endcase
    endtask

    // Run one instruction step by step; abort_at >= 0 pulses clr after that step
    task automatic run_instr(input string name, input logic [31:0] instr,
                             input int w1, input int wm, input int abort_at);
        int n;
        build(instr, w1, wm);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check($sformatf("%s[%0d]", name, i), obs, exp_q[i]);
            mem_rdy = rdy_q[i];
            ir      = irv_q[i];
            if (i == abort_at) begin
                clr = 1'b1;
                #1;
                check($sformatf("%s_clr", name), obs, 80'd0);
                @(negedge clock);
                check($sformatf("%s_clr_hold", name), obs, 80'd0);
                clr = 1'b0;
                break;
            end
        end
        $display("instr %-6s ir=%h steps=%0d", name, instr, n);
    endtask

    initial begin
        logic [4:0]  ops [11];
        logic [4:0]  op5;
        logic [31:0] r;
        int          wm_w;

        wm_w = WAIT_EN ? 3 : 0;

        // Reset: everything quiet, run low
        repeat (2) begin
            @(negedge clock);
            check("reset", obs, 80'd0);
        end
        clr = 1'b0;

        // Directed instructions from the test plan
        run_instr("ldi", 32'h0880_0005, 0, 0, -1);
        run_instr("add", {5'd3, 4'd2, 4'd3, 4'd4, 15'd0}, 0, 0, -1);
        run_instr("sub", {5'd4, 4'd2, 4'd3, 4'd4, 15'd0}, 0, 0, -1);
        run_instr("and", {5'd5, 4'd1, 4'd5, 4'd6, 15'd0}, 0, 0, -1);
        run_instr("or",  {5'd6, 4'd7, 4'd5, 4'd6, 15'd0}, 0, 0, -1);
        run_instr("ld",  {5'd0, 4'd3, 4'd1, 19'h40}, 0, wm_w, -1);
        run_instr("st",  {5'd2, 4'd3, 4'd1, 19'h44}, WAIT_EN ? 2 : 0, WAIT_EN ? 2 : 0, -1);
        run_instr("nop", {5'd26, 27'd0}, 0, 0, -1);
        run_instr("undef", {5'd31, 27'h123}, 0, 0, -1);
        run_instr("addi", {5'd12, 4'd2, 4'd2, 19'h7}, 0, 0, 4);
        run_instr("ldi2", 32'h0880_0005, 0, 0, -1);

        // Randomized instruction stream
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd26, 5'd31, 5'd9};
        for (int t = 0; t < 60; t++) begin
            op5 = ops[$urandom_range(0, 10)];
            if (op5 == 5'd9) op5 = 5'($urandom_range(7, 11));
            r = $urandom;
            run_instr($sformatf("rnd%0d", t), {op5, r[26:0]},
                      WAIT_EN ? $urandom_range(0, 3) : 0,
                      WAIT_EN ? $urandom_range(0, 3) : 0, -1);
        end

        // halt parks with everything low until clr
        run_instr("halt", {5'd27, 27'h55}, 0, 0, -1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check($sformatf("halted[%0d]", c), obs, 80'd0);
            mem_rdy = rnd_bit();
            ir      = $urandom;
        end
        clr = 1'b1;
        #1;
        check("halt_clr", obs, 80'd0);
        @(negedge clock);
        clr = 1'b0;
        run_instr("refetch", 32'h0880_0005, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
